// File: rtl/div_pkg.sv
// Shared encodings and helpers for the multi-cycle EX-stage divider.
package div_pkg;

  // Divider FSM encodings (2-bit).
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Result-valid levels.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Request levels driven by EX on start_i.
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam int unsigned DivWidth = 32;

  // Two's-complement magnitude of an operand when it is treated as signed
  // and negative; otherwise the value passes through untouched.
  function automatic logic [DivWidth-1:0] div_mag(input logic [DivWidth-1:0] v,
                                                  input logic            is_signed);
    div_mag = (is_signed && v[DivWidth-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU. Produces one quotient bit per
// cycle and returns {remainder, quotient} for the HI/LO write.
//
// Handshake: EX raises start_i with stable operands and keeps it high until
// it sees ready_o. ready_o/result_o are registered and held while start_i
// stays high in END; dropping start_i returns the divider to FREE on the
// next edge with both outputs cleared. annul_i cancels an operation in
// BYZERO or ON, blocks acceptance in FREE, and is ignored in END.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output div_state_e  dbg_state
);

  div_state_e  state;
  div_state_e  state_nxt;

  logic [5:0]  cnt;
  // The partial remainder is always below the divisor magnitude, so 32 bits
  // hold it; the shifted trial value below carries the 33rd bit.
  logic [31:0] rem_q;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in.
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic        sign1_q;
  logic        sign2_q;
  logic        sdiv_q;
  logic [63:0] res_q;

  logic [32:0] shifted;
  logic        fit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  logic        accept;

  assign accept    = (start_i == DivStart) && !annul_i;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DivFree;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DivFree: begin
        if (accept) state_nxt = (opdata2_i == 32'd0) ? DivByZero : DivOn;
      end
      DivByZero: begin
        state_nxt = annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (annul_i)           state_nxt = DivFree;
        else if (cnt == 6'd31) state_nxt = DivEnd;
      end
      DivEnd: begin
        if (start_i == DivStop) state_nxt = DivFree;
      end
      default: state_nxt = DivFree;
    endcase
  end

  // One restoring iteration plus the sign fix-up of the final step.
  always_comb begin
    shifted  = {rem_q, dvd_q[31]};
    fit      = (shifted >= {1'b0, dsr_q});
    rem_step = fit ? (shifted[31:0] - dsr_q) : shifted[31:0];
    quo_step = {dvd_q[30:0], fit};
    quo_fin  = (sdiv_q && (sign1_q ^ sign2_q)) ? (~quo_step + 32'd1) : quo_step;
    rem_fin  = (sdiv_q && sign1_q) ? (~rem_step + 32'd1) : rem_step;
  end

  // Datapath registers: operand capture, iteration, result latch, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 6'd0;
      rem_q    <= 32'd0;
      dvd_q    <= 32'd0;
      dsr_q    <= 32'd0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      sdiv_q   <= 1'b0;
      res_q    <= 64'd0;
      result_o <= 64'd0;
      ready_o  <= DivResultNotReady;
    end else begin
      result_o <= 64'd0;
      ready_o  <= DivResultNotReady;
      unique case (state)
        DivFree: begin
          if (accept && (opdata2_i != 32'd0)) begin
            dvd_q   <= div_mag(opdata1_i, signed_div_i);
            dsr_q   <= div_mag(opdata2_i, signed_div_i);
            sign1_q <= signed_div_i & opdata1_i[31];
            sign2_q <= signed_div_i & opdata2_i[31];
            sdiv_q  <= signed_div_i;
            cnt     <= 6'd0;
            rem_q   <= 32'd0;
          end
        end
        DivByZero: begin
          res_q <= 64'd0;
        end
        DivOn: begin
          if (!annul_i) begin
            rem_q <= rem_step;
            dvd_q <= quo_step;
            cnt   <= cnt + 6'd1;
            if (cnt == 6'd31) res_q <= {rem_fin, quo_fin};
          end
        end
        DivEnd: begin
          if (start_i == DivStart) begin
            result_o <= res_q;
            ready_o  <= DivResultReady;
          end else begin
            cnt <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for the EX-stage divider: reset, unsigned/signed results,
// corner operands, divide-by-zero, annul and asynchronous reset.
module tb_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  div_state_e  dbg_state;

  int total;
  int bad;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .dbg_state    (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and wait (bounded) for ready_o; check latency and result.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat);
    int n;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();  // edge 0: accepted in FREE
    // Operands must be ignored after acceptance.
    opdata1_i = $urandom_range(1, 32'hFFFF);
    opdata2_i = $urandom_range(1, 32'hFFFF);
    n = 0;
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
  endtask

  // Drop start_i and confirm the return to FREE with cleared outputs.
  task automatic end_div(input string tag);
    start_i = 1'b0;
    tick();
    check({tag, " ready low"}, {63'd0, ready_o}, 64'd0);
    check({tag, " result cleared"}, result_o, 64'd0);
    check({tag, " state free"}, {62'd0, dbg_state}, {62'd0, DivFree});
  endtask

  initial begin
    logic rose;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    // Reset state.
    #2;
    repeat (2) tick();
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset state", {62'd0, dbg_state}, {62'd0, DivFree});
    rst = 1'b0;
    tick();

    // Unsigned.
    run_div("u 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    end_div("u 100/7");
    run_div("u fffffff9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
    end_div("u fffffff9/2");

    // Signed.
    run_div("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    end_div("s -7/2");
    run_div("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    end_div("s 7/-2");

    // Corners.
    run_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    end_div("s min/-1");
    run_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    end_div("u max/1");

    // Divide by zero.
    run_div("u 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
    check("u 5/0 ready", {63'd0, ready_o}, 64'd1);
    end_div("u 5/0");

    // Annul in FREE blocks acceptance.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    tick();
    check("annul blocks accept", {62'd0, dbg_state}, {62'd0, DivFree});
    annul_i = 1'b0;

    // Annul mid-ON: accepted at edge 0, annulled at edge 11.
    tick();
    rose = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ready_o) rose = 1'b1;
    end
    check("annul in ON before", {62'd0, dbg_state}, {62'd0, DivOn});
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    if (ready_o) rose = 1'b1;
    check("annul to free", {62'd0, dbg_state}, {62'd0, DivFree});
    check("annul ready never rose", {63'd0, rose}, 64'd0);
    annul_i = 1'b0;
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    end_div("after annul 9/3");

    // Asynchronous reset mid-ON.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    tick();
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async rst state", {62'd0, dbg_state}, {62'd0, DivFree});
    check("async rst ready", {63'd0, ready_o}, 64'd0);
    check("async rst result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    tick();

    // Post-reset divide, then hold start_i in END.
    run_div("post rst 1/1", 1'b0, 32'd1, 32'd1, {32'd0, 32'd1}, 33);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold ready", {63'd0, ready_o}, 64'd1);
      check("hold result", result_o, {32'd0, 32'd1});
    end
    end_div("post rst 1/1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
